alu_share_arbiter: RTL
======================

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- RR_EN, default 1: 1 = round-robin grant; 0 = fixed priority, requester 0 wins.
- CNT_W, default 8: width of the completed-operation counter.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- req0_valid, in, 1: requester 0 has an operation pending.
- req0_ready, out, 1: requester 0 operation accepted this cycle.
- req0_a / req0_b, in, 4: requester 0 operands.
- req0_op, in, 2: requester 0 op code; 00 ADD, 01 SUB, 10 AND, 11 OR.
- req1_valid / req1_ready / req1_a / req1_b / req1_op: same as requester 0, for requester 1.
- rsp0_valid, out, 1: requester 0 result held.
- rsp0_ready, in, 1: requester 0 consumes its result.
- rsp0_result, out, 4: requester 0 result.
- rsp0_carry, out, 1: requester 0 carry/borrow.
- rsp1_valid / rsp1_ready / rsp1_result / rsp1_carry: same as requester 0, for requester 1.
- alu_a / alu_b, out, 4: operands driven to the shared 4-bit ALU.
- alu_op, out, 2: op code driven to the shared ALU.
- alu_result, in, 4: combinational ALU result.
- alu_carry, in, 1: combinational ALU carry out.
- busy, out, 1: high while in state EXEC.
- op_count, out, CNT_W: count of completed operations.

REQ-003 Reset SHALL be asynchronous on rst_n low: one clock, reset asynchronous, active-low.

Function
REQ-004 FSM states SHALL be IDLE and EXEC; the reset state SHALL be IDLE.
REQ-005 Requester i SHALL be eligible in IDLE only when reqi_valid=1 and rspi_valid=0.
REQ-006 In IDLE, exactly one eligible requester SHALL be granted, and its reqi_ready SHALL be 1 combinationally; reqi_ready SHALL be 0 in EXEC and for non-granted requesters.
REQ-007 With RR_EN=1 and both requesters eligible, the grant SHALL go to the requester not granted last; last_grant SHALL reset to 1, so requester 0 wins the first tie.
REQ-008 With RR_EN=0, requester 0 SHALL always win a tie.
REQ-009 On the accept edge (IDLE, valid&ready):
- the granted operands and op SHALL load into alu_a, alu_b and alu_op;
- the owner id and last_grant SHALL update;
- the state SHALL become EXEC.
REQ-010 alu_a, alu_b and alu_op SHALL be registered and SHALL hold their last values in IDLE.
REQ-011 On the EXEC edge:
- alu_result SHALL load into the owner's rsp result;
- the owner's rsp_valid SHALL be set;
- the state SHALL return to IDLE;
- op_count SHALL increment.
REQ-012 The rsp carry SHALL capture alu_carry for op 00 or 01 and SHALL be 0 for op 10 or 11.
REQ-013 Latency: rsp_valid SHALL rise in the cycle immediately after the EXEC cycle, 2 edges after acceptance.
REQ-014 Throughput SHALL be at most one operation per 2 cycles.
REQ-015 rspi_valid SHALL clear on an edge where rspi_valid=1 and rspi_ready=1; rspi_ready while rspi_valid=0 SHALL be ignored.
REQ-016 rspi_result and rspi_carry SHALL remain stable while rspi_valid=1.
REQ-017 A requester whose response is not consumed SHALL not be granted, while the other requester SHALL still be served.
REQ-018 op_count SHALL wrap from all-ones to 0.
REQ-019 A reqi_valid drop before acceptance SHALL withdraw that request without side effect.
REQ-020 busy SHALL be 1 exactly in EXEC.

Reset
REQ-021 On rst_n low, from any state, the block SHALL go to IDLE, and the following SHALL be 0:
- alu_a, alu_b, alu_op;
- rsp0/1_valid, rsp0/1_result, rsp0/1_carry;
- op_count.
On the same reset, last_grant SHALL be 1.
REQ-022 Reset during EXEC SHALL abort the in-flight operation with no response generated.
REQ-023 On the first edge after rst_n rises, the FSM SHALL evaluate from IDLE.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Requester 0, a=9, b=8, op=00 -> rsp0_result=1, rsp0_carry=1, rsp0_valid rises 2 edges after accept.
- Requester 1, a=3, b=5, op=01 -> rsp1_result=E, rsp1_carry=0; then a=5, b=3, op=01 -> result=2, carry=1.
- Both requesters valid continuously, RR_EN=1, rsp_ready held 1 -> grants alternate 0,1,0,1 and op_count=4 after 8 cycles.
- rsp0_ready held 0, both requesters valid -> requester 0 served once, then only requester 1 is granted until rsp0 is drained.
- op=11, a=A, b=5 with alu_carry forced 1 -> result=F, carry=0.
- rst_n pulsed low in EXEC -> no rsp_valid appears, all outputs return to 0, and requester 0 wins the next tie.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Two-requester front end for a single shared 4-bit combinational ALU.
// It grants one request in IDLE, executes for one cycle in EXEC and holds each result until consumed.
module alu_share_arbiter #(
    parameter bit RR_EN = 1'b1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    input  logic [1:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [3:0]       rsp0_result,
    output logic             rsp0_carry,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [3:0]       rsp1_result,
    output logic             rsp1_carry,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [1:0]       alu_op,
    input  logic [3:0]       alu_result,
    input  logic             alu_carry,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    // Handshakes: a request transfers on an edge where reqi_valid and reqi_ready are both 1;
    // a response transfers (and rspi_valid drops) on an edge where rspi_valid and rspi_ready are both 1.

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EXEC = 1'b1;

    logic [0:0] state;
    logic       owner;
    logic       last_grant;
    logic       elig0;
    logic       elig1;
    logic       grant_any;
    logic       grant_id;
    logic       exec_carry;

    // A requester still holding an unconsumed result sits out arbitration.
    always_comb begin
        elig0     = req0_valid & ~rsp0_valid;
        elig1     = req1_valid & ~rsp1_valid;
        grant_any = (state == IDLE) & (elig0 | elig1);
        grant_id  = elig1;
        if (elig0 && elig1) begin
            grant_id = RR_EN ? ~last_grant : 1'b0;
        end
    end

    assign req0_ready = grant_any & ~grant_id;
    assign req1_ready = grant_any & grant_id;
    assign busy       = (state == EXEC);

    // Logic ops have no meaningful carry, so whatever the ALU reports is masked.
    assign exec_carry = alu_op[1] ? 1'b0 : alu_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            alu_a       <= 4'd0;
            alu_b       <= 4'd0;
            alu_op      <= 2'd0;
            rsp0_valid  <= 1'b0;
            rsp0_result <= 4'd0;
            rsp0_carry  <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp1_result <= 4'd0;
            rsp1_carry  <= 1'b0;
            op_count    <= '0;
        end else begin
            if (rsp0_valid && rsp0_ready) begin
                rsp0_valid <= 1'b0;
            end
            if (rsp1_valid && rsp1_ready) begin
                rsp1_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        alu_a      <= grant_id ? req1_a  : req0_a;
                        alu_b      <= grant_id ? req1_b  : req0_b;
                        alu_op     <= grant_id ? req1_op : req0_op;
                        owner      <= grant_id;
                        last_grant <= grant_id;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (owner) begin
                        rsp1_valid  <= 1'b1;
                        rsp1_result <= alu_result;
                        rsp1_carry  <= exec_carry;
                    end else begin
                        rsp0_valid  <= 1'b1;
                        rsp0_result <= alu_result;
                        rsp0_carry  <= exec_carry;
                    end
                    op_count <= op_count + CNT_W'(1);
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
